data_sram_like_ram: RTL and testbench
=====================================

// Module: data_sram_like_ram
// PURPOSE
//  Responder (slave) end of the sram-like data port driven by the mips core: data_req/wr/size/addr/wdata in,
//  data_addr_ok/data_ok/rdata out. Word-organised RAM with byte-lane writes, configurable response latency
//  and a bounded in-order queue of outstanding requests. Sits beside the instruction ROM in the core-level
//  testbench, so that load/store tests run against a real responder.
// PARAMETERS
//  ADDR_WIDTH   10  word-index bits; RAM holds 2**ADDR_WIDTH 32-bit words; uses addr[ADDR_WIDTH+1:2]
//  LATENCY      2   cycles from accept edge to data_ok (legal 1..8)
//  QUEUE_DEPTH  2   max outstanding accepted-but-unanswered requests (legal 1..8)
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  data_req      in   1   request valid
//  data_wr       in   1   1=write, 0=read
//  data_size     in   2   0=byte, 1=half, 2=word, 3=treated as word
//  data_addr     in   32  byte address; bits above ADDR_WIDTH+1 ignored
//  data_wdata    in   32  write data, already placed in its byte lanes
//  data_rdata    out  32  full aligned word; valid only while data_data_ok=1
//  data_addr_ok  out  1   request accepted this cycle when data_req & data_addr_ok
//  data_data_ok  out  1   one-cycle response pulse per accepted request, in order
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high; no other clock or async reset.
//  - Reset values: data_addr_ok=0 during rst, then 1; data_data_ok=0; data_rdata=0. Queue cleared.
//    RAM contents are NOT reset. Preloaded via $readmemh on hierarchical array "mem".
//  - data_addr_ok = !rst && (count < QUEUE_DEPTH). It depends on registered state only, never on data_req.
//    There is no same-cycle pop-then-push bypass.
//  - Accept at posedge T when data_req & data_addr_ok:
//      * Write: RAM is updated at edge T. Byte-enable comes from size and addr[1:0]:
//        byte -> 1<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
//      * Read: the word is captured at edge T, before any same-edge write to another entry.
//        A later-accepted write therefore never alters an earlier read's data.
//      * The queue entry holds {is_read, rdata, countdown=LATENCY-1}.
//  - Each cycle, every queued entry with countdown>0 decrements.
//    When the head has countdown==0, data_data_ok=1 for exactly that cycle. data_rdata is the head's data
//    for reads and 0 for writes. The head pops at the next edge.
//  - Responses are strictly in acceptance order, at most one per cycle. Back-to-back accepts give
//    back-to-back data_ok. Sustained throughput is 1/cycle iff QUEUE_DEPTH >= LATENCY.
//  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) is accepted and answered normally.
//    The byte-enable uses the formulas above; the excess lanes shift out and are dropped. No exception is raised.
//  - Simultaneous accept and pop in one cycle: count is unchanged and both take effect.
//  - Reset mid-operation: all outstanding entries are discarded and no data_ok is issued for them.
//    Writes already accepted remain in RAM.
//  - data_wdata/data_size/data_addr are sampled only on the accept edge and ignored otherwise.
//  - Implementation: circular buffer with head/tail pointers plus count. The RAM is a reg array with a
//    per-lane write.
// TESTING
//  1. Reset: hold rst 3 cycles with data_req=1 -> addr_ok=0 and data_ok=0 throughout.
//     First cycle after reset addr_ok=1.
//  2. Word write 0xDEADBEEF @0x10, then read @0x10 (LATENCY=2) -> each data_ok arrives 2 edges after its
//     accept; read rdata=0xDEADBEEF.
//  3. Byte write 0xAA in lane 1 (addr 0x11, wdata 0x0000AA00) over 0x11223344
//     -> read @0x10 returns 0x1122AA44. Half write addr 0x12, wdata 0x55660000 -> 0x5566AA44.
//  4. Four back-to-back reads with QUEUE_DEPTH=1, LATENCY=2 -> addr_ok low 1 of every 2 cycles,
//     4 in-order data_ok. With DEPTH=2 -> 4 consecutive data_ok.
//  5. Read @0x20 (holds 0x1) accepted, then write 0x2 @0x20 next cycle -> read returns 0x1;
//     a subsequent read returns 0x2.
//  6. Assert rst while 2 requests are outstanding -> no data_ok afterwards; the accepted write remains
//     visible on the next read.

Source files
------------

// File: rtl/data_sram_like_ram.sv
// data_sram_like_ram: sram-like data-port responder with lane writes, fixed latency and an in-order request queue
module data_sram_like_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
  localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic r_q_rd [QUEUE_DEPTH];
  logic [31:0] r_q_data [QUEUE_DEPTH];
  logic [3:0] r_q_cd [QUEUE_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic r_data_ok;
  logic [31:0] r_rdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0] w_be;
  logic w_acc, w_push, w_pop, w_fire, w_fire_rd, w_unused;
  logic [31:0] w_rd_word, w_fire_data;
  logic [PW-1:0] w_head_nxt, w_tail_nxt;
  assign data_addr_ok = !rst && (r_count < CW'(QUEUE_DEPTH));
  assign data_data_ok = r_data_ok;
  assign data_rdata = r_rdata;
  // decode the request and select what moves into the response register this edge
  always_comb begin
    w_idx = data_addr[ADDR_WIDTH+1:2];
    w_be = data_size == 2'd0 ? 4'b0001 << data_addr[1:0] : data_size == 2'd1 ? 4'b0011 << {data_addr[1], 1'b0} : 4'b1111;
    w_acc = data_req && data_addr_ok;
    w_push = w_acc && LATENCY > 1;
    w_pop = r_count != '0 && r_q_cd[r_head] == 4'd1;
    w_rd_word = mem[w_idx];
    w_fire = LATENCY == 1 ? w_acc : w_pop;
    w_fire_rd = LATENCY == 1 ? !data_wr : r_q_rd[r_head];
    w_fire_data = LATENCY == 1 ? w_rd_word : r_q_data[r_head];
    w_head_nxt = r_head == LAST ? '0 : r_head + 1'b1;
    w_tail_nxt = r_tail == LAST ? '0 : r_tail + 1'b1;
    w_unused = ^data_addr[31:ADDR_WIDTH+2];
  end
  // RAM lanes are written on the accept edge; contents survive reset
  always_ff @(posedge clk)
    if (w_acc && data_wr)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
  // queue: the head leaves for the registered response on its last countdown step, so data_ok is sampled LATENCY edges after accept
  always_ff @(posedge clk)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_data_ok <= 1'b0;
      r_rdata <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (r_q_cd[i] != 4'd0) r_q_cd[i] <= r_q_cd[i] - 4'd1;
      if (w_push) begin
        r_q_rd[r_tail] <= !data_wr;
        r_q_data[r_tail] <= w_rd_word;
        r_q_cd[r_tail] <= CD_INIT;
        r_tail <= w_tail_nxt;
      end
      if (w_pop) r_head <= w_head_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_data_ok <= w_fire;
      r_rdata <= w_fire && w_fire_rd ? w_fire_data : 32'd0;
    end
endmodule

// File: tb/tb_data_sram_like_ram.sv
// tb_data_sram_like_ram: cycle-table checks on a depth-2 responder plus a throttling sequence on a depth-1 one
module tb_data_sram_like_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, wr, aok, ok;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata;
  logic rst1, req1, wr1, aok1, ok1;
  logic [1:0] size1;
  logic [31:0] addr1, wdata1, rdata1;
  int checks = 0;
  int errors = 0;
  data_sram_like_ram #(.ADDR_WIDTH(10), .LATENCY(2), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(size), .data_addr(addr),
    .data_wdata(wdata), .data_rdata(rdata), .data_addr_ok(aok), .data_data_ok(ok));
  data_sram_like_ram #(.ADDR_WIDTH(10), .LATENCY(2), .QUEUE_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst1), .data_req(req1), .data_wr(wr1), .data_size(size1), .data_addr(addr1),
    .data_wdata(wdata1), .data_rdata(rdata1), .data_addr_ok(aok1), .data_data_ok(ok1));
  typedef struct {
    logic rs, rq, w;
    logic [1:0] sz;
    logic [31:0] a, d;
    logic aok, cok, ok;
    logic [31:0] rd;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic rs, rq, w, input logic [1:0] sz, input logic [31:0] a, d,
                              input logic cok, ok, input logic [31:0] rd);
    vec_t v;
    v.rs = rs; v.rq = rq; v.w = w; v.sz = sz; v.a = a; v.d = d;
    v.aok = !rs; v.cok = cok; v.ok = ok; v.rd = rd;
    return v;
  endfunction
  function automatic vec_t idle(input logic ok, input logic [31:0] rd);
    return mk(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, ok, rd);
  endfunction
  function automatic vec_t wrv(input logic [1:0] sz, input logic [31:0] a, d, input logic ok, input logic [31:0] rd);
    return mk(1'b0, 1'b1, 1'b1, sz, a, d, 1'b1, ok, rd);
  endfunction
  function automatic vec_t rdv(input logic [31:0] a, input logic ok, input logic [31:0] rd);
    return mk(1'b0, 1'b1, 1'b0, 2'd2, a, 32'h0, 1'b1, ok, rd);
  endfunction
  task automatic d1_write(input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = a; wdata1 = d;
    #1;
    while (!aok1 && k < 8) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("d1 write accept", 32'(aok1), 32'd1);
    @(posedge clk);
    #1;
    req1 = 1'b0; wr1 = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0;
    rst1 = 1'b1; req1 = 1'b0; wr1 = 1'b0; size1 = 2'd2; addr1 = '0; wdata1 = '0;
    repeat (3) vq.push_back(mk(1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0));
    vq.push_back(wrv(2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0));
    vq.push_back(rdv(32'h10, 1'b0, 32'h0));
    vq.push_back(idle(1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'hDEADBEEF));
    vq.push_back(idle(1'b0, 32'h0));
    vq.push_back(wrv(2'd2, 32'h10, 32'h11223344, 1'b0, 32'h0));
    vq.push_back(wrv(2'd0, 32'h11, 32'h0000AA00, 1'b0, 32'h0));
    vq.push_back(rdv(32'h10, 1'b1, 32'h0));
    vq.push_back(wrv(2'd1, 32'h12, 32'h55660000, 1'b1, 32'h0));
    vq.push_back(rdv(32'h10, 1'b1, 32'h1122AA44));
    vq.push_back(idle(1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h5566AA44));
    vq.push_back(idle(1'b0, 32'h0));
    vq.push_back(wrv(2'd2, 32'h20, 32'h1, 1'b0, 32'h0));
    vq.push_back(rdv(32'h20, 1'b0, 32'h0));
    vq.push_back(wrv(2'd2, 32'h20, 32'h2, 1'b1, 32'h0));
    vq.push_back(rdv(32'h20, 1'b1, 32'h1));
    vq.push_back(idle(1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h2));
    vq.push_back(idle(1'b0, 32'h0));
    vq.push_back(wrv(2'd2, 32'h31, 32'hCAFEF00D, 1'b0, 32'h0));
    vq.push_back(wrv(2'd1, 32'h33, 32'h12340000, 1'b0, 32'h0));
    vq.push_back(rdv(32'h30, 1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h1234F00D));
    vq.push_back(rdv(32'hFFFFF010, 1'b0, 32'h0));
    vq.push_back(idle(1'b0, 32'h0));
    vq.push_back(idle(1'b1, 32'h5566AA44));
    vq.push_back(rdv(32'h10, 1'b0, 32'h0));
    vq.push_back(rdv(32'h20, 1'b0, 32'h0));
    vq.push_back(rdv(32'h30, 1'b1, 32'h5566AA44));
    vq.push_back(rdv(32'h10, 1'b1, 32'h2));
    vq.push_back(idle(1'b1, 32'h1234F00D));
    vq.push_back(idle(1'b1, 32'h5566AA44));
    vq.push_back(wrv(2'd0, 32'h13, 32'h77000000, 1'b0, 32'h0));
    vq.push_back(wrv(2'd0, 32'h10, 32'h000000EE, 1'b0, 32'h0));
    vq.push_back(rdv(32'h10, 1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h0));
    vq.push_back(idle(1'b1, 32'h7766AAEE));
    vq.push_back(wrv(2'd2, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0));
    vq.push_back(rdv(32'h40, 1'b0, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0));
    vq.push_back(rdv(32'h40, 1'b0, 32'h0));
    vq.push_back(idle(1'b0, 32'h0));
    vq.push_back(idle(1'b1, 32'hA5A5A5A5));
    vq.push_back(idle(1'b0, 32'h0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rs; req = vq[i].rq; wr = vq[i].w; size = vq[i].sz; addr = vq[i].a; wdata = vq[i].d;
      #1;
      chk($sformatf("v%0d addr_ok", i), 32'(aok), 32'(vq[i].aok));
      if (vq[i].cok) chk($sformatf("v%0d data_ok", i), 32'(ok), 32'(vq[i].ok));
      if (vq[i].ok) chk($sformatf("v%0d rdata", i), rdata, vq[i].rd);
    end
    for (int i = 0; i < 4; i++) d1_write(32'(i * 4), 32'hA0000000 + 32'(i));
    repeat (4) @(posedge clk);
    begin
      int idx = 0;
      for (int n = 0; n < 10; n++) begin
        logic acc;
        logic eok;
        @(negedge clk);
        req1 = idx < 4; wr1 = 1'b0; size1 = 2'd2; addr1 = 32'(idx * 4);
        #1;
        eok = n == 2 || n == 4 || n == 6 || n == 8;
        chk($sformatf("d1 c%0d addr_ok", n), 32'(aok1), 32'(n % 2 == 0 || n >= 8));
        chk($sformatf("d1 c%0d data_ok", n), 32'(ok1), 32'(eok));
        if (eok) chk($sformatf("d1 c%0d rdata", n), rdata1, 32'hA0000000 + 32'(n / 2 - 1));
        acc = req1 && aok1;
        @(posedge clk);
        if (acc) idx++;
      end
      #1;
      req1 = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
